// File: rtl/mem_port_arbiter.sv
// Shares one bus master port between instruction fetch and load/store.
// Data requests win unless fetch has been starved for MAX_D_BURST grants.
module mem_port_arbiter #(
   parameter int MAX_D_BURST = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic        if_err_o,
   output logic [31:0] if_data_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic        d_size_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_ack_o,
   output logic        d_err_o,
   output logic [31:0] d_rdata_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [31:0] bus_adr_o,
   output logic [31:0] bus_dat_o,
   output logic [3:0]  bus_sel_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack_i
);

   // state  | meaning
   // IDLE   | arbitrate between fetch and data requests
   // BUSY   | bus cycle in flight, waiting for ack or timeout
   // RESP   | one-cycle ack to the granted requester
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  r_state;
   logic        r_gnt_d;
   logic        r_we;
   logic        r_size;
   logic [1:0]  r_lane;
   logic [3:0]  r_dburst;
   logic [7:0]  r_tmo;
   logic        r_cyc;
   logic        r_bus_we;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_if_ack;
   logic        r_if_err;
   logic [31:0] r_if_data;
   logic        r_d_ack;
   logic        r_d_err;
   logic [31:0] r_d_rdata;

   logic        w_burst_full;
   logic        w_gnt_d;
   logic        w_gnt_if;
   logic        w_d_mis;
   logic        w_if_mis;
   logic        w_tmo_hit;
   logic [3:0]  w_sel_byte;
   logic [7:0]  w_lane_byte;
   logic [31:0] w_load_data;

   assign w_burst_full = (r_dburst == 4'(MAX_D_BURST));
   assign w_gnt_d      = d_req_i && !(if_req_i && w_burst_full);
   assign w_gnt_if     = !w_gnt_d && if_req_i;
   assign w_d_mis      = d_size_i && (d_addr_i[1:0] != 2'b00);
   assign w_if_mis     = (if_addr_i[1:0] != 2'b00);
   assign w_sel_byte   = 4'b0001 << d_addr_i[1:0];
   // TIMEOUT of 0 wraps the compare value out of reach, disabling the abort
   assign w_tmo_hit    = (TIMEOUT != 0) && ({1'b0, r_tmo} == 9'(TIMEOUT - 1));

   always_comb begin
      w_lane_byte = bus_dat_i[7:0];
      case (r_lane)
         2'd1:    w_lane_byte = bus_dat_i[15:8];
         2'd2:    w_lane_byte = bus_dat_i[23:16];
         2'd3:    w_lane_byte = bus_dat_i[31:24];
         default: w_lane_byte = bus_dat_i[7:0];
      endcase
   end

   assign w_load_data = r_size ? bus_dat_i : {{24{w_lane_byte[7]}}, w_lane_byte};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_gnt_d   <= 1'b0;
         r_we      <= 1'b0;
         r_size    <= 1'b0;
         r_lane    <= 2'd0;
         r_dburst  <= 4'd0;
         r_tmo     <= 8'd0;
         r_cyc     <= 1'b0;
         r_bus_we  <= 1'b0;
         r_adr     <= 32'd0;
         r_dat     <= 32'd0;
         r_sel     <= 4'd0;
         r_if_ack  <= 1'b0;
         r_if_err  <= 1'b0;
         r_if_data <= 32'd0;
         r_d_ack   <= 1'b0;
         r_d_err   <= 1'b0;
         r_d_rdata <= 32'd0;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;

         if (!if_req_i)
            r_dburst <= 4'd0;
         else if (r_state == S_IDLE && w_gnt_if)
            r_dburst <= 4'd0;
         else if (r_state == S_IDLE && w_gnt_d && !w_burst_full)
            r_dburst <= r_dburst + 4'd1;

         case (r_state)
            S_IDLE: begin
               if (w_gnt_d) begin
                  r_gnt_d <= 1'b1;
                  r_we    <= d_we_i;
                  r_size  <= d_size_i;
                  r_lane  <= d_addr_i[1:0];
                  if (w_d_mis) begin
                     r_state   <= S_RESP;
                     r_d_ack   <= 1'b1;
                     r_d_err   <= 1'b1;
                     r_d_rdata <= 32'd0;
                  end else begin
                     r_state  <= S_BUSY;
                     r_tmo    <= 8'd0;
                     r_cyc    <= 1'b1;
                     r_bus_we <= d_we_i;
                     r_adr    <= {d_addr_i[31:2], 2'b00};
                     r_dat    <= d_size_i ? d_wdata_i : {4{d_wdata_i[7:0]}};
                     r_sel    <= d_size_i ? 4'b1111 : w_sel_byte;
                  end
               end else if (w_gnt_if) begin
                  r_gnt_d <= 1'b0;
                  r_we    <= 1'b0;
                  r_size  <= 1'b1;
                  r_lane  <= 2'd0;
                  if (w_if_mis) begin
                     r_state   <= S_RESP;
                     r_if_ack  <= 1'b1;
                     r_if_err  <= 1'b1;
                     r_if_data <= 32'd0;
                  end else begin
                     r_state  <= S_BUSY;
                     r_tmo    <= 8'd0;
                     r_cyc    <= 1'b1;
                     r_bus_we <= 1'b0;
                     r_adr    <= {if_addr_i[31:2], 2'b00};
                     r_dat    <= 32'd0;
                     r_sel    <= 4'b1111;
                  end
               end
            end
            S_BUSY: begin
               if (bus_ack_i || w_tmo_hit) begin
                  r_cyc   <= 1'b0;
                  r_state <= S_RESP;
                  if (r_gnt_d) begin
                     r_d_ack   <= 1'b1;
                     r_d_err   <= !bus_ack_i;
                     r_d_rdata <= (bus_ack_i && !r_we) ? w_load_data : 32'd0;
                  end else begin
                     r_if_ack  <= 1'b1;
                     r_if_err  <= !bus_ack_i;
                     r_if_data <= bus_ack_i ? bus_dat_i : 32'd0;
                  end
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_ack_o  = r_if_ack;
   assign if_err_o  = r_if_err;
   assign if_data_o = r_if_data;
   assign d_ack_o   = r_d_ack;
   assign d_err_o   = r_d_err;
   assign d_rdata_o = r_d_rdata;
   assign bus_cyc_o = r_cyc;
   assign bus_stb_o = r_cyc;
   assign bus_we_o  = r_bus_we;
   assign bus_adr_o = r_adr;
   assign bus_dat_o = r_dat;
   assign bus_sel_o = r_sel;

endmodule
